// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, stall patterns and controller state encodings for the
// pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int RegisterBus = 32;
    localparam int StallBus    = 6;

    localparam logic [StallBus-1:0] StallNone = 6'b000000;
    localparam logic [StallBus-1:0] StallID   = 6'b000111;
    localparam logic [StallBus-1:0] StallEX   = 6'b001111;

    typedef enum logic [1:0] {
        CtrlIdle  = 2'd0,
        CtrlMcRun = 2'd1,
        CtrlFlush = 2'd2
    } ctrl_state_e;

    // A multi-cycle request with zero cycles is treated as no request at all.
    function automatic logic mc_request(input logic start, input logic [5:0] cycles);
        return start && (cycles != 6'd0);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
// The master side raises requests; the slave side (pipe_ctrl) answers them.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
();

    logic                   id_stall_req;
    logic                   ex_mc_start;
    logic [5:0]             ex_mc_cycles;
    logic                   flush_req;
    logic [RegisterBus-1:0] flush_pc;

    logic [StallBus-1:0]    stall;
    logic                   flush;
    logic [RegisterBus-1:0] new_pc;
    logic                   ex_mc_done;
    logic                   busy;
    logic [31:0]            stall_cycles;

    modport master (
        output id_stall_req, ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
        input  stall, flush, new_pc, ex_mc_done, busy, stall_cycles
    );

    modport slave (
        input  id_stall_req, ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
        output stall, flush, new_pc, ex_mc_done, busy, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_sat_cnt32.sv
// Saturating 32-bit event counter: counts enabled cycles and sticks at all-ones.
module sat_cnt32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 32'd0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: arbitrates MEM redirects, EX multi-cycle ops
// and ID load-use hazards into the per-stage stall vector and flush/new_pc pair.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave bus
);

    ctrl_state_e            state_q, state_d;
    logic [5:0]             cnt_q, cnt_d;
    logic                   flush_q;
    logic [RegisterBus-1:0] new_pc_q;
    logic [StallBus-1:0]    stall_c;
    logic                   done_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CtrlIdle;
            cnt_q    <= 6'd0;
            flush_q  <= 1'b0;
            new_pc_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= bus.flush_req;
            if (bus.flush_req) begin
                new_pc_q <= bus.flush_pc;
            end
        end
    end

    // Redirects outrank everything, including an op that is already running;
    // while reset is held the pipeline must see no stall and no done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = StallNone;
        done_c  = 1'b0;

        if (rst) begin
            state_d = CtrlIdle;
            cnt_d   = 6'd0;
        end else if (bus.flush_req) begin
            state_d = CtrlFlush;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                CtrlIdle: begin
                    if (mc_request(bus.ex_mc_start, bus.ex_mc_cycles)) begin
                        stall_c = StallEX;
                        if (bus.ex_mc_cycles == 6'd1) begin
                            done_c = 1'b1;
                        end else begin
                            cnt_d   = bus.ex_mc_cycles - 6'd1;
                            state_d = CtrlMcRun;
                        end
                    end else if (bus.id_stall_req) begin
                        stall_c = StallID;
                    end
                end
                CtrlMcRun: begin
                    stall_c = StallEX;
                    cnt_d   = cnt_q - 6'd1;
                    if (cnt_q <= 6'd1) begin
                        done_c  = 1'b1;
                        cnt_d   = 6'd0;
                        state_d = CtrlIdle;
                    end
                end
                CtrlFlush: begin
                    state_d = CtrlIdle;
                end
                default: begin
                    state_d = CtrlIdle;
                    cnt_d   = 6'd0;
                end
            endcase
        end
    end

    sat_cnt32 u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_c[0]),
        .count (bus.stall_cycles)
    );

    assign bus.stall      = stall_c;
    assign bus.ex_mc_done = done_c;
    assign bus.flush      = flush_q;
    assign bus.new_pc     = new_pc_q;
    assign bus.busy       = (state_q != CtrlIdle);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl against a cycle-level model of
// remaining stall cycles and pending redirects.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference state: stall cycles still owed to an op, pending flush pulse,
    // its target, the stall counter, and whether a reset has defined the DUT.
    int          m_left  = 0;
    bit          m_flush = 1'b0;
    logic [31:0] m_pc    = 32'd0;
    logic [31:0] m_cnt   = 32'd0;
    bit          m_known = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got=%h want=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit ids, input bit mcs,
                                 input logic [5:0] n, input bit fr, input logic [31:0] fpc);
        logic [5:0] e_stall;
        bit         e_done;
        @(negedge clk);
        rst              = r;
        bus.id_stall_req = ids;
        bus.ex_mc_start  = mcs;
        bus.ex_mc_cycles = n;
        bus.flush_req    = fr;
        bus.flush_pc     = fpc;
        #1;
        if (m_known) begin
            checkOutput("flush", {31'd0, bus.flush}, {31'd0, m_flush});
            if (m_flush) checkOutput("new_pc", bus.new_pc, m_pc);
            checkOutput("busy", {31'd0, bus.busy}, {31'd0, (m_flush || m_left > 0)});
            checkOutput("stall_cycles", bus.stall_cycles, m_cnt);
        end
        e_stall = 6'b000000;
        e_done  = 1'b0;
        if (r) begin
            m_left  = 0;
            m_flush = 1'b0;
            m_pc    = 32'd0;
            m_cnt   = 32'd0;
            m_known = 1'b1;
        end else if (fr) begin
            m_left  = 0;
            m_flush = 1'b1;
            m_pc    = fpc;
        end else if (m_flush) begin
            m_flush = 1'b0;
        end else if (m_left > 0) begin
            e_stall = 6'b001111;
            e_done  = (m_left == 1);
            m_left  = m_left - 1;
        end else if (mcs && n != 6'd0) begin
            e_stall = 6'b001111;
            e_done  = (n == 6'd1);
            m_left  = int'(n) - 1;
        end else if (ids) begin
            e_stall = 6'b000111;
        end
        checkOutput("stall", {26'd0, bus.stall}, {26'd0, e_stall});
        checkOutput("ex_mc_done", {31'd0, bus.ex_mc_done}, {31'd0, e_done});
        if (!r && e_stall[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(0, 0, 0, 6'd0, 0, 32'd0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.id_stall_req = 1'b0;
        bus.ex_mc_start  = 1'b0;
        bus.ex_mc_cycles = 6'd0;
        bus.flush_req    = 1'b0;
        bus.flush_pc     = 32'd0;

        $display("[TB] reset with every request raised");
        applyStimulus(1, 1, 1, 6'd5, 1, 32'hDEAD_BEEF);
        applyStimulus(1, 1, 1, 6'd5, 1, 32'hDEAD_BEEF);
        idle(1);

        $display("[TB] load-use stall");
        applyStimulus(0, 1, 0, 6'd0, 0, 32'd0);
        idle(2);

        $display("[TB] multi-cycle op N=4 with ignored id stall");
        applyStimulus(0, 0, 1, 6'd4, 0, 32'd0);
        applyStimulus(0, 1, 0, 6'd0, 0, 32'd0);
        idle(4);

        $display("[TB] boundary N=1 and N=0");
        applyStimulus(0, 0, 1, 6'd1, 0, 32'd0);
        idle(1);
        applyStimulus(0, 0, 1, 6'd0, 0, 32'd0);
        idle(1);

        $display("[TB] abort N=8 by redirect");
        applyStimulus(0, 0, 1, 6'd8, 0, 32'd0);
        idle(1);
        applyStimulus(0, 1, 1, 6'd3, 1, 32'h0000_0020);
        idle(3);

        $display("[TB] simultaneous start and redirect, then back-to-back redirects");
        applyStimulus(0, 0, 1, 6'd5, 1, 32'h0000_0100);
        idle(2);
        applyStimulus(0, 0, 0, 6'd0, 1, 32'h0000_0100);
        applyStimulus(0, 1, 1, 6'd2, 1, 32'h0000_0200);
        idle(2);

        $display("[TB] reset mid-operation");
        applyStimulus(0, 0, 1, 6'd9, 0, 32'd0);
        idle(2);
        applyStimulus(1, 0, 0, 6'd0, 0, 32'd0);
        idle(2);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            bit          r, ids, mcs, fr;
            logic [5:0]  n;
            logic [31:0] fpc;
            r   = ($urandom_range(0, 199) == 0);
            ids = $urandom_range(0, 1);
            mcs = ($urandom_range(0, 3) == 0);
            n   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
            fr  = ($urandom_range(0, 19) == 0);
            fpc = $urandom;
            applyStimulus(r, ids, mcs, n, fr, fpc);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
